// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - time-multiplexed 6-digit 7-segment scan driver (option: LEADING_ZERO_BLANK_EN)
module clock_display_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       EN,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    output logic [6:0] Seg,
    output logic       DP,
    output logic [5:0] Dig
);

    localparam int           PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]   IDX_LAST   = 3'd5;
    localparam logic [6:0]   SEG_POL    = {7{SEG_ACTIVE_LOW}};
    localparam logic [5:0]   DIG_POL    = {6{DIG_ACTIVE_LOW}};

    // Scan timing and frame snapshot state
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   snap_q, snap_d;
    logic          first_q, first_d;

    // Registered display outputs, already in pin polarity
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    dig_q, dig_d;

    // Active-high intermediates
    logic [3:0]    nib;
    logic [6:0]    seg_ah;
    logic          dp_ah;
    logic [5:0]    dig_ah;
    logic          tick;

    // 8421 BCD to segments {g,f,e,d,c,b,a}; non-decimal nibbles show a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Prescaler, digit index and snapshot next-state; snapshot only moves at frame
    // boundaries (or right after reset) so a frame never mixes old and new time
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        first_d = 1'b0;
        tick    = (presc_q == PRESC_LAST);

        if (first_q) begin
            snap_d = {Hour, Minute, Second};
        end

        if (tick) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d  = 3'd0;
                snap_d = {Hour, Minute, Second};
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Digit select, decode, separator and blanking for the digit at idx_q
    always_comb begin
        nib    = 4'd0;
        dig_ah = 6'b000000;
        case (idx_q)
            3'd0:    begin nib = snap_q[3:0];   dig_ah = 6'b000001; end
            3'd1:    begin nib = snap_q[7:4];   dig_ah = 6'b000010; end
            3'd2:    begin nib = snap_q[11:8];  dig_ah = 6'b000100; end
            3'd3:    begin nib = snap_q[15:12]; dig_ah = 6'b001000; end
            3'd4:    begin nib = snap_q[19:16]; dig_ah = 6'b010000; end
            3'd5:    begin nib = snap_q[23:20]; dig_ah = 6'b100000; end
            default: begin nib = 4'd0;          dig_ah = 6'b000000; end
        endcase

        seg_ah = seg_decode(nib);
        // H.MM.SS separators blink with the seconds units LSB
        dp_ah  = ((idx_q == 3'd2) || (idx_q == 3'd4)) && !snap_q[0];

`ifdef LEADING_ZERO_BLANK_EN
        // Keep the hour tens strobe but show nothing when it is a leading zero
        if ((idx_q == 3'd5) && (snap_q[23:20] == 4'd0)) begin
            seg_ah = 7'h00;
            dp_ah  = 1'b0;
        end
`endif

        if (!EN) begin
            dig_ah = 6'b000000;
            seg_ah = 7'h00;
            dp_ah  = 1'b0;
        end

        seg_d = seg_ah ^ SEG_POL;
        dp_d  = dp_ah ^ SEG_ACTIVE_LOW;
        dig_d = dig_ah ^ DIG_POL;
    end

    // All state, including outputs, registered together so Dig and Seg switch in the same cycle
    always_ff @(posedge CP) begin
        if (CR) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            snap_q  <= 24'h000000;
            first_q <= 1'b1;
            seg_q   <= SEG_POL;
            dp_q    <= SEG_ACTIVE_LOW;
            dig_q   <= DIG_POL;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            first_q <= first_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
        end
    end

    assign Seg = seg_q;
    assign DP  = dp_q;
    assign Dig = dig_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - scoreboard bench for clock_display_scan
module tb_clock_display_scan;

    localparam int SCAN_DIV = 4;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic       EN = 1'b1;
    logic [7:0] Hour = 8'h23;
    logic [7:0] Minute = 8'h59;
    logic [7:0] Second = 8'h48;
    logic [6:0] Seg;
    logic       DP;
    logic [5:0] Dig;

    clock_display_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .CP     (CP),
        .CR     (CR),
        .EN     (EN),
        .Hour   (Hour),
        .Minute (Minute),
        .Second (Second),
        .Seg    (Seg),
        .DP     (DP),
        .Dig    (Dig)
    );

    always #5 CP = ~CP;

    typedef struct packed {
        logic [5:0] dig;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_presc;
    int          m_idx;
    logic [23:0] m_snap;
    bit          m_first;

    // Active-high view of what each digit showed during a capture window
    logic [6:0] obs_seg [6];
    logic       obs_dp  [6];
    int         obs_cnt [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < 6; i++) begin
            obs_seg[i] = 7'h00;
            obs_dp[i]  = 1'b0;
            obs_cnt[i] = 0;
        end
    endtask

    // One clock: predict, push, clock, pop and compare
    task automatic step();
        exp_t       e;
        logic [6:0] s_ah;
        logic       d_ah;
        logic [5:0] d_sel;
        if (CR) begin
            e = '{dig: 6'h3F, seg: 7'h7F, dp: 1'b1};
            m_presc = 0;
            m_idx   = 0;
            m_snap  = 24'h000000;
            m_first = 1'b1;
        end else begin
            if (!EN) begin
                e = '{dig: 6'h3F, seg: 7'h7F, dp: 1'b1};
            end else begin
                d_sel = 6'b000001 << m_idx;
                s_ah  = ref_seg(m_snap[m_idx*4 +: 4]);
                d_ah  = ((m_idx == 2) || (m_idx == 4)) && !m_snap[0];
`ifdef LEADING_ZERO_BLANK_EN
                if ((m_idx == 5) && (m_snap[23:20] == 4'd0)) begin
                    s_ah = 7'h00;
                    d_ah = 1'b0;
                end
`endif
                e.dig = ~d_sel;
                e.seg = ~s_ah;
                e.dp  = ~d_ah;
            end
            if (m_first) begin
                m_snap  = {Hour, Minute, Second};
                m_first = 1'b0;
            end
            if (m_presc == SCAN_DIV - 1) begin
                m_presc = 0;
                if (m_idx == 5) begin
                    m_idx  = 0;
                    m_snap = {Hour, Minute, Second};
                end else begin
                    m_idx = m_idx + 1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
        sb_q.push_back(e);
        @(posedge CP);
        #1;
        e = sb_q.pop_front();
        check("dig", Dig, e.dig);
        check("seg", Seg, e.seg);
        check("dp", DP, e.dp);
        check("onehot", ($countones(~Dig) <= 1), 1);
        for (int i = 0; i < 6; i++) begin
            if (Dig[i] == 1'b0) begin
                obs_seg[i] = ~Seg;
                obs_dp[i]  = ~DP;
                obs_cnt[i] = obs_cnt[i] + 1;
            end
        end
        @(negedge CP);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_idx(input int target);
        int k;
        k = 0;
        while ((m_idx != target) && (k < 64)) begin
            step();
            k++;
        end
        check("idx_reach", (m_idx == target), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear_obs();
        @(negedge CP);

        // Reset state
        CR = 1'b1;
        step();
        step();
        check("rst_dig", Dig, 6'h3F);
        check("rst_seg", Seg, 7'h7F);
        check("rst_dp", DP, 1'b1);
        CR = 1'b0;
        step();
        check("rel_dig0", Dig[0], 1'b0);

        // Full frame of 23:59:48
        run(30);
        clear_obs();
        run(24);
        check("f_seg0", obs_seg[0], 7'h7F);
        check("f_seg1", obs_seg[1], 7'h66);
        check("f_seg2", obs_seg[2], 7'h6F);
        check("f_seg3", obs_seg[3], 7'h6D);
        check("f_seg4", obs_seg[4], 7'h4F);
        check("f_seg5", obs_seg[5], 7'h5B);
        for (int i = 0; i < 6; i++) begin
            check("f_hold", obs_cnt[i], SCAN_DIV);
            check("f_dp", obs_dp[i], ((i == 2) || (i == 4)) ? 1 : 0);
        end

        // Mid-frame input change must not tear the frame
        run_until_idx(2);
        Second = 8'h49;
        run_until_idx(0);
        clear_obs();
        run(24);
        check("t_seg0", obs_seg[0], 7'h6F);
        check("t_dp2", obs_dp[2], 1'b0);
        check("t_dp4", obs_dp[4], 1'b0);

        // Invalid BCD nibble shows a dash
        Second = 8'h4A;
        run(30);
        clear_obs();
        run(24);
        check("dash_seg0", obs_seg[0], 7'h40);
        check("dash_seg1", obs_seg[1], 7'h66);
        check("dash_seg5", obs_seg[5], 7'h5B);

        // Blank mid idx 3, then resume in sequence
        run_until_idx(3);
        step();
        EN = 1'b0;
        step();
        check("en0_dig", Dig, 6'h3F);
        check("en0_seg", Seg, 7'h7F);
        step();
        EN = 1'b1;
        step();
        check("en1_dig", Dig, 6'h37);
        run(12);

        // Hour tens zero
        Hour = 8'h05;
        run(30);
        clear_obs();
        run(24);
        check("h_cnt5", obs_cnt[5], SCAN_DIV);
        check("h_seg4", obs_seg[4], 7'h6D);
`ifdef LEADING_ZERO_BLANK_EN
        check("h_seg5", obs_seg[5], 7'h00);
`else
        check("h_seg5", obs_seg[5], 7'h3F);
`endif

        // Reset mid-frame
        run_until_idx(3);
        CR = 1'b1;
        step();
        check("cr_dig", Dig, 6'h3F);
        check("cr_seg", Seg, 7'h7F);
        CR = 1'b0;
        step();
        check("cr_idx0", Dig, 6'h3E);
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
